piso_yumi: RTL and testbench

- Drain-side consumer for fifo_1r1w's valid/yumi output port.
- Takes one wide word per yumi and serializes it into els_p narrow beats on a valid/ready output toward a narrow link or sink.
- Sits directly behind fifo_1r1w and is the other end of that block's valid_o/data_o/yumi_i interface.

---
 rtl/piso_yumi_pkg.sv | 11 +
 rtl/piso_yumi_counter_clear_up.sv | 33 +++
 rtl/piso_yumi.sv | 67 ++++++
 tb/tb_piso_yumi.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/piso_yumi_pkg.sv
// Shared types and helpers for the piso_yumi wide-to-narrow serializer.
// The counter width helper keeps single-beat configurations at one bit.
package piso_yumi_pkg;

  typedef enum logic [0:0] {IDLE, BUSY} piso_state_e;

  function automatic int unsigned cnt_width(input int unsigned els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage

// File: rtl/piso_yumi_counter_clear_up.sv
// Beat counter 0..max_val_p with synchronous clear (priority) and increment; wraps at max.
// Zero latency on last_o; holds its value when neither clear nor up is asserted.
module counter_clear_up
  import piso_yumi_pkg::*;
#(
  parameter int unsigned max_val_p = 3,
  localparam int unsigned cw_lp = cnt_width(max_val_p + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             up_i,
  output logic [cw_lp-1:0] count_o,
  output logic             last_o
);

  logic [cw_lp-1:0] count_r;

  assign last_o  = (count_r == cw_lp'(max_val_p));
  assign count_o = count_r;

  // Wrapping on last keeps the count inside 0..max_val_p for any max value.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else if (clear_i) begin
      count_r <= '0;
    end else if (up_i) begin
      count_r <= last_o ? '0 : count_r + cw_lp'(1);
    end
  end

endmodule

// File: rtl/piso_yumi.sv
// Serializes one width_p*els_p word per yumi into els_p beats; first beat one cycle after yumi_o,
// back-to-back words at full rate; ready_i low freezes the beat. PISO_YUMI_MSB_FIRST_EN selects MSB-first order.
module piso_yumi
  import piso_yumi_pkg::*;
#(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  input  logic [width_p*els_p-1:0]   data_i,
  output logic                       yumi_o,
  output logic                       valid_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       ready_i
);

  localparam int unsigned cw_lp = cnt_width(els_p);

  piso_state_e                     state_r;
  logic [els_p-1:0][width_p-1:0]   word_r;
  logic [cw_lp-1:0]                count;
  logic [cw_lp-1:0]                beat_idx;
  logic                            last_beat;
  logic                            busy;
  logic                            beat_taken;

  assign busy       = (state_r == BUSY);
  assign beat_taken = busy & ready_i;
  assign valid_o    = busy;

  // Gated by reset so the upstream FIFO never loses a word while we are held in reset.
  assign yumi_o = ~reset_i & valid_i & (~busy | (last_beat & beat_taken));

  counter_clear_up #(
    .max_val_p(els_p - 1)
  ) beat_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(yumi_o),
    .up_i   (beat_taken & ~last_beat),
    .count_o(count),
    .last_o (last_beat)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      word_r  <= '0;
    end else if (yumi_o) begin
      state_r <= BUSY;
      word_r  <= data_i;
    end else if (beat_taken && last_beat) begin
      state_r <= IDLE;
    end
  end

`ifdef PISO_YUMI_MSB_FIRST_EN
  assign beat_idx = cw_lp'(els_p - 1) - count;
`else
  assign beat_idx = count;
`endif

  assign data_o = word_r[beat_idx];

endmodule

// File: tb/tb_piso_yumi.sv
// Scoreboarded bench for piso_yumi: FIFO-like source, stallable sink, reset and els_p=3 cases.
module tb_piso_yumi;

  localparam int W   = 8;
  localparam int ELS = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                valid_i, yumi_o, valid_o, ready_i;
  logic [W*ELS-1:0]    data_i;
  logic [W-1:0]        data_o;

  logic                v3, y3, vo3, r3;
  logic [W*3-1:0]      d3;
  logic [W-1:0]        do3;

  int n_cmp = 0;
  int n_err = 0;

  logic [W*ELS-1:0] src[$];
  logic [W-1:0]     sb[$];
  bit               m_busy;
  int               m_cnt;

  always #5 clk = ~clk;

  piso_yumi #(.width_p(W), .els_p(ELS)) dut (
    .clk_i(clk), .reset_i(reset), .valid_i(valid_i), .data_i(data_i),
    .yumi_o(yumi_o), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i)
  );

  piso_yumi #(.width_p(W), .els_p(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .valid_i(v3), .data_i(d3),
    .yumi_o(y3), .valid_o(vo3), .data_o(do3), .ready_i(r3)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W*ELS-1:0] w);
    int idx;
    src.push_back(w);
    for (int b = 0; b < ELS; b++) begin
`ifdef PISO_YUMI_MSB_FIRST_EN
      idx = ELS - 1 - b;
`else
      idx = b;
`endif
      sb.push_back(w[idx*W +: W]);
    end
    valid_i = 1'b1;
    data_i  = src[0];
  endtask

  // Called just after a negedge with inputs set; checks, advances the model, moves to next negedge.
  task automatic tick();
    bit exp_yumi;
    #1;
    exp_yumi = valid_i && (!m_busy || (m_cnt == ELS - 1 && ready_i));
    check_eq("valid_o", valid_o, m_busy);
    check_eq("yumi_o", yumi_o, exp_yumi);
    if (valid_o) begin
      if (sb.size() == 0) check_eq("sb_underflow", 1, 0);
      else if (!ready_i) check_eq("hold_data", data_o, sb[0]);
      else check_eq("beat", data_o, sb.pop_front());
    end
    if (m_busy && ready_i && m_cnt != ELS - 1) m_cnt++;
    else if (exp_yumi) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      void'(src.pop_front());
    end else if (m_busy && ready_i) m_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid_i = (src.size() != 0);
    data_i  = valid_i ? src[0] : '0;
  endtask

  initial begin
    logic [7:0]  e3_d[8];
    logic [7:0]  e3_v, e3_y, in3_v;
    reset = 1'b1; ready_i = 1'b1; valid_i = 1'b1; data_i = 32'hDEADBEEF;
    v3 = 1'b0; d3 = '0; r3 = 1'b1;
    m_busy = 0; m_cnt = 0;

    #12;
    check_eq("rst_valid_o", valid_o, 0);
    check_eq("rst_yumi_o", yumi_o, 0);
    check_eq("rst_data_o", data_o, 0);
    @(negedge clk);
    reset = 1'b0; valid_i = 1'b0; data_i = '0;

    // Single word, LSB first by default.
    push_word(32'hDDCCBBAA);
    repeat (6) tick();

    // Back-to-back words: eight beats with no bubble.
    push_word(32'h44332211);
    push_word(32'h88776655);
    repeat (10) tick();

    // Three-cycle stall on the second beat.
    push_word(32'hDDCCBBAA);
    repeat (2) tick();
    ready_i = 1'b0;
    repeat (3) tick();
    ready_i = 1'b1;
    repeat (4) tick();

    // Async reset after the second beat drops the rest of the word.
    push_word(32'hDDCCBBAA);
    push_word(32'h04030201);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check_eq("arst_valid_o", valid_o, 0);
    check_eq("arst_yumi_o", yumi_o, 0);
    repeat (ELS - 2) void'(sb.pop_front());
    m_busy = 0; m_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) tick();
    check_eq("sb_empty", sb.size(), 0);
    check_eq("src_empty", src.size(), 0);

    // els_p=3: two words, yumi re-asserted on the last beat of the first.
    e3_v  = 8'b0111_1110;
    e3_y  = 8'b0000_1001;
    in3_v = 8'b0000_1111;
`ifdef PISO_YUMI_MSB_FIRST_EN
    e3_d  = '{8'h00, 8'h33, 8'h22, 8'h11, 8'h66, 8'h55, 8'h44, 8'h00};
`else
    e3_d  = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
`endif
    for (int c = 0; c < 8; c++) begin
      v3 = in3_v[c];
      d3 = (c == 0) ? 24'h332211 : (in3_v[c] ? 24'h665544 : 24'h0);
      #1;
      check_eq($sformatf("e3_valid_c%0d", c), vo3, e3_v[c]);
      check_eq($sformatf("e3_yumi_c%0d", c), y3, e3_y[c]);
      if (e3_v[c]) check_eq($sformatf("e3_data_c%0d", c), do3, e3_d[c]);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
